ctrl_varredura_matriz: RTL and testbench

- Scan controller for the 5x7 LED dot-matrix driven by the 3-bit symbol decoder.
- Selects the symbol index presented to the decoder (sel → decoder inputs A,B,C = sel[2],sel[1],sel[0]).
- Captures the decoder's 35-bit bitmap once per frame and multiplexes it row by row onto the matrix.
- Supports manual symbol load or automatic cycling through the 8 symbols.

---
 rtl/ctrl_varredura_matriz.sv | 206 ++++++++++++++++++++
 tb/tb_ctrl_varredura_matriz.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_varredura_matriz.sv
// ---------------------------------------------------------------------------
// ctrl_varredura_matriz
//
// Scan controller for a 5x7 LED dot matrix fed by a 3-bit symbol decoder.
// The controller chooses the symbol index shown to the decoder, captures the
// decoder bitmap once per frame and multiplexes it onto the matrix one row at
// a time. Symbols are either loaded manually or cycled automatically.
//
// Frame structure: one LATCH cycle followed by seven rows of DIV cycles each,
// i.e. 1 + 7*DIV cycles per frame.
//
// Parameters
//   DIV         clock cycles each row stays lit (>= 2)
//   FRAMES_SYM  frames each symbol stays on screen in auto mode (>= 1)
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   en          1 = scanning active, 0 = display blanked
//   modo        0 = manual, 1 = auto-advance
//   load        one-cycle pulse: sel <- sel_in
//   sel_in[2:0] symbol index to load
//   mapa[34:0]  decoder bitmap, row r / column c at bit 5r+c, 1 = dot on
//   sel[2:0]    symbol index to the decoder (A,B,C = sel[2],sel[1],sel[0])
//   linha[6:0]  row drive, one-hot, active-high
//   coluna[4:0] column drive, active-low
//   frame_done  one-cycle pulse at the end of each frame
// ---------------------------------------------------------------------------
module ctrl_varredura_matriz #(
    parameter int DIV        = 50000,
    parameter int FRAMES_SYM = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        modo,
    input  logic        load,
    input  logic [2:0]  sel_in,
    input  logic [34:0] mapa,
    output logic [2:0]  sel,
    output logic [6:0]  linha,
    output logic [4:0]  coluna,
    output logic        frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (FRAMES_SYM > 1) ? $clog2(FRAMES_SYM) : 1;

    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
    localparam logic [CW-1:0] FLAST = CW'(FRAMES_SYM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SCAN  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [2:0]    row, row_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [CW-1:0] fcnt, fcnt_n;
    logic [34:0]   frame, frame_n;
    logic [2:0]    sel_n;
    logic [6:0]    linha_n;
    logic [4:0]    coluna_n;
    logic          done_n;
    logic          tick;

    // Five dots of row r from a captured bitmap.
    function automatic logic [4:0] dots(input logic [34:0] f, input logic [2:0] r);
        logic [4:0] d;
        case (r)
            3'd0:    d = f[4:0];
            3'd1:    d = f[9:5];
            3'd2:    d = f[14:10];
            3'd3:    d = f[19:15];
            3'd4:    d = f[24:20];
            3'd5:    d = f[29:25];
            3'd6:    d = f[34:30];
            default: d = 5'b00000;
        endcase
        return d;
    endfunction

    assign tick = (state == SCAN) && (pcnt == PLAST);

    // -----------------------------------------------------------------------
    // State register and all registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= 3'd0;
            pcnt       <= '0;
            fcnt       <= '0;
            frame      <= '0;
            sel        <= 3'd0;
            linha      <= 7'b0000000;
            coluna     <= 5'b11111;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            pcnt       <= pcnt_n;
            fcnt       <= fcnt_n;
            frame      <= frame_n;
            sel        <= sel_n;
            linha      <= linha_n;
            coluna     <= coluna_n;
            frame_done <= done_n;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state, prescaler, row and frame capture
    // -----------------------------------------------------------------------
    always_comb begin
        state_n = state;
        row_n   = row;
        pcnt_n  = pcnt;
        frame_n = frame;
        done_n  = 1'b0;

        if (!en) begin
            // Blanking wins in every state; restart always goes via LATCH.
            state_n = IDLE;
            row_n   = 3'd0;
            pcnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = LATCH;
                    row_n   = 3'd0;
                    pcnt_n  = '0;
                end
                LATCH: begin
                    // sel has been stable for at least this cycle, so mapa
                    // already shows the symbol chosen at the previous edge.
                    frame_n = mapa;
                    row_n   = 3'd0;
                    pcnt_n  = '0;
                    state_n = SCAN;
                end
                SCAN: begin
                    if (tick) begin
                        pcnt_n = '0;
                        if (row == 3'd6) begin
                            state_n = LATCH;
                            row_n   = 3'd0;
                            done_n  = 1'b1;
                        end else begin
                            row_n = row + 3'd1;
                        end
                    end else begin
                        pcnt_n = pcnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    row_n   = 3'd0;
                    pcnt_n  = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output drive, computed from next-state values so that the matrix
    // changes on the same edge as the state/row. Only SCAN lights a row,
    // and linha_n is a single shifted bit, so two rows never overlap.
    // -----------------------------------------------------------------------
    always_comb begin
        linha_n  = 7'b0000000;
        coluna_n = 5'b11111;
        if (state_n == SCAN) begin
            linha_n  = 7'b0000001 << row_n;
            coluna_n = ~dots(frame_n, row_n);
        end
    end

    // -----------------------------------------------------------------------
    // Symbol selection. Counter only moves at frame ends or on load, so a
    // mid-frame modo change is seen at the next frame end without disturbing
    // the count. A load on the advance edge takes priority.
    // -----------------------------------------------------------------------
    always_comb begin
        sel_n  = sel;
        fcnt_n = fcnt;
        if (load) begin
            sel_n  = sel_in;
            fcnt_n = '0;
        end else if (done_n) begin
            if (modo) begin
                if (fcnt == FLAST) begin
                    sel_n  = sel + 3'd1;
                    fcnt_n = '0;
                end else begin
                    fcnt_n = fcnt + 1'b1;
                end
            end else begin
                fcnt_n = '0;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_varredura_matriz.sv
// ---------------------------------------------------------------------------
// tb_ctrl_varredura_matriz
//
// Directed bench for ctrl_varredura_matriz with DIV=4, FRAMES_SYM=2.
// Frame = 29 cycles. Expected values are written out by hand in the sequence.
// ---------------------------------------------------------------------------
module tb_ctrl_varredura_matriz;

    localparam int DIV = 4;
    localparam int FS  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        modo;
    logic        load;
    logic [2:0]  sel_in;
    logic [34:0] mapa;
    logic [2:0]  sel;
    logic [6:0]  linha;
    logic [4:0]  coluna;
    logic        frame_done;

    logic [34:0] mapa_drv;
    logic        use_dec;

    int n_run  = 0;
    int n_fail = 0;

    // Row 0..6 bitmaps: row0=01100 ... row6=10001
    localparam logic [34:0] P1 = {5'b10001, 5'b10000, 5'b01000, 5'b00100,
                                  5'b00010, 5'b00001, 5'b01100};
    localparam logic [34:0] P2 = {5'b11111, 5'b00011, 5'b00110, 5'b01110,
                                  5'b11000, 5'b10101, 5'b01010};

    // Stand-in symbol decoder: row0 = {01,s}, row6 = {s,01}, rest dark.
    function automatic logic [34:0] dec(input logic [2:0] s);
        return {s, 2'b01, 25'h0, 2'b01, s};
    endfunction

    assign mapa = use_dec ? dec(sel) : mapa_drv;

    ctrl_varredura_matriz #(.DIV(DIV), .FRAMES_SYM(FS)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .modo       (modo),
        .load       (load),
        .sel_in     (sel_in),
        .mapa       (mapa),
        .sel        (sel),
        .linha      (linha),
        .coluna     (coluna),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Ticks until frame_done is seen (bounded); returns cycles taken.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!frame_done && n < 100);
        if (n >= 100) chk("done_timeout", 64'(n), 64'd0);
    endtask

    // Called with SCAN row 0 just lit. Checks every scan cycle against fr,
    // optionally pulsing load at the first cycle of row ld_row and swapping
    // the bitmap afterwards. Returns in LATCH.
    task automatic scan_frame(input logic [34:0] fr, input int ld_row,
                              input logic [2:0] ld_val, input logic [34:0] nmap);
        logic [6:0] el;
        logic [4:0] ec;
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < DIV; k++) begin
                el = 7'b0000001 << r;
                ec = ~fr[r*5 +: 5];
                chk("scan_linha", 64'(linha), 64'(el));
                chk("scan_coluna", 64'(coluna), 64'(ec));
                if (k == 0) chk("scan_nodone", 64'(frame_done), 64'd0);
                if (r == ld_row && k == 0) begin
                    load   = 1'b1;
                    sel_in = ld_val;
                    tick(1);
                    load     = 1'b0;
                    mapa_drv = nmap;
                    chk("load_sel", 64'(sel), 64'(ld_val));
                end else begin
                    tick(1);
                end
            end
        end
        chk("frame_done", 64'(frame_done), 64'd1);
        chk("latch_linha", 64'(linha), 64'd0);
        chk("latch_coluna", 64'(coluna), 64'h1f);
    endtask

    initial begin
        int n;
        logic [4:0] ec;
        logic [6:0] el;

        rst      = 1'b1;
        en       = 1'b0;
        modo     = 1'b0;
        load     = 1'b0;
        sel_in   = 3'd0;
        mapa_drv = '0;
        use_dec  = 1'b0;

        // Reset state
        #1;
        chk("rst_linha", 64'(linha), 64'd0);
        chk("rst_coluna", 64'(coluna), 64'h1f);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);

        // Release, IDLE -> LATCH -> SCAN
        @(posedge clk); #1;
        rst      = 1'b0;
        en       = 1'b1;
        mapa_drv = P1;
        tick(1);
        chk("latch1_linha", 64'(linha), 64'd0);
        chk("latch1_coluna", 64'(coluna), 64'h1f);
        tick(1);
        scan_frame(P1, 7, 3'd0, P1);

        // Tear-free load of symbol 5 while row 3 is lit
        tick(1);
        scan_frame(P1, 3, 3'd5, P2);
        chk("tear_sel", 64'(sel), 64'd5);
        tick(1);
        scan_frame(P2, 7, 3'd0, P2);

        // Auto-advance from 7 with FRAMES_SYM=2
        modo    = 1'b1;
        load    = 1'b1;
        sel_in  = 3'd7;
        use_dec = 1'b1;
        tick(1);
        load = 1'b0;
        chk("auto_start_sel", 64'(sel), 64'd7);
        wait_done(n);
        chk("auto_a_period", 64'(n), 64'd28);
        chk("auto_a_sel", 64'(sel), 64'd7);
        wait_done(n);
        chk("auto_b_period", 64'(n), 64'd29);
        chk("auto_b_sel", 64'(sel), 64'd0);
        tick(1);
        chk("auto_b_linha", 64'(linha), 64'd1);
        chk("auto_b_coluna", 64'(coluna), 64'h17);   // ~01000
        wait_done(n);
        chk("auto_c_sel", 64'(sel), 64'd0);
        wait_done(n);
        chk("auto_d_period", 64'(n), 64'd29);
        chk("auto_d_sel", 64'(sel), 64'd1);
        wait_done(n);
        chk("auto_e_sel", 64'(sel), 64'd1);
        // Frame F: load lands on the advance edge
        tick(28);
        chk("auto_f_row6", 64'(linha), 64'h40);
        load   = 1'b1;
        sel_in = 3'd3;
        tick(1);
        load = 1'b0;
        chk("coinc_done", 64'(frame_done), 64'd1);
        chk("coinc_sel", 64'(sel), 64'd3);
        wait_done(n);
        chk("auto_g_sel", 64'(sel), 64'd3);
        wait_done(n);
        chk("auto_h_sel", 64'(sel), 64'd4);
        tick(1);
        chk("auto_h_coluna", 64'(coluna), 64'h13);   // ~01100

        // Enable drop during row 4, load while blanked
        modo    = 1'b0;
        use_dec = 1'b0;
        tick(16);
        chk("en_row4", 64'(linha), 64'h10);
        en = 1'b0;
        tick(1);
        chk("en_off_linha", 64'(linha), 64'd0);
        chk("en_off_coluna", 64'(coluna), 64'h1f);
        chk("en_off_done", 64'(frame_done), 64'd0);
        load   = 1'b1;
        sel_in = 3'd6;
        tick(1);
        load = 1'b0;
        chk("en_off_load", 64'(sel), 64'd6);
        chk("en_off_idle", 64'(linha), 64'd0);
        en = 1'b1;
        tick(1);
        chk("en_latch", 64'(linha), 64'd0);
        tick(1);
        for (int k = 0; k < DIV; k++) begin
            chk("en_row0", 64'(linha), 64'd1);
            tick(1);
        end
        chk("en_row1", 64'(linha), 64'd2);
        wait_done(n);
        chk("en_rest", 64'(n), 64'd24);

        // Walking single dot across all 35 bitmap bits
        for (int b = 0; b < 35; b++) begin
            mapa_drv = 35'd1 << b;
            tick(1);
            for (int r = 0; r < 7; r++) begin
                el = 7'b0000001 << r;
                ec = (r == b / 5) ? ~(5'b00001 << (b % 5)) : 5'b11111;
                chk("walk_linha", 64'(linha), 64'(el));
                chk("walk_coluna", 64'(coluna), 64'(ec));
                tick(DIV);
            end
            chk("walk_done", 64'(frame_done), 64'd1);
        end

        // Asynchronous reset in the middle of row 2
        tick(9);
        chk("pre_rst_row2", 64'(linha), 64'h04);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_linha", 64'(linha), 64'd0);
        chk("mid_rst_coluna", 64'(coluna), 64'h1f);
        chk("mid_rst_sel", 64'(sel), 64'd0);
        chk("mid_rst_done", 64'(frame_done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);
        chk("post_rst_latch", 64'(linha), 64'd0);
        tick(1);
        chk("post_rst_row0", 64'(linha), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected finish", n_run);
        $fatal(1);
    end

endmodule
